// File: rtl/lupa_pkg.sv
// Shared definitions for the LUPA configuration sequencer: state encoding,
// register-select codes and the default upload table.
package lupa_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_FINISH    = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

    localparam logic [3:0] NRG_NONE   = 4'h0;
    localparam logic [3:0] NRG_HEADER = 4'h8;
    localparam logic [3:0] NRG_REG1   = 4'h1;
    localparam logic [3:0] NRG_REG2   = 4'h2;
    localparam logic [3:0] NRG_REG3   = 4'h3;
    localparam logic [3:0] NRG_REG4   = 4'h4;
    localparam logic [3:0] NRG_REG5   = 4'h5;
    localparam logic [3:0] NRG_REG6   = 4'h6;
    localparam logic [3:0] NRG_REG7   = 4'h7;

    // Entry 0 sits in the least significant nibble.
    localparam logic [63:0] CFG_TABLE_DEFAULT = {
        {8{NRG_NONE}},
        NRG_REG7, NRG_REG6, NRG_REG5, NRG_REG4,
        NRG_REG3, NRG_REG2, NRG_REG1, NRG_HEADER
    };

    function automatic logic [3:0] cfg_table_entry(input logic [3:0] addr);
        return CFG_TABLE_DEFAULT[{addr, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/lupa_cfg_rom.sv
// 16x4 synchronous ROM holding the register-select codes issued per sequence.
module lupa_cfg_rom
    import lupa_pkg::*;
(
    input  logic       clock_40,
    input  logic [3:0] addr,
    output logic [3:0] data
);

    always_ff @(posedge clock_40) begin
        data <= cfg_table_entry(addr);
    end

endmodule

// File: rtl/lupa_cfg_seq.sv
// Configuration sequencer: walks the ROM table and hands each register-select
// code to the SPI uploader with a start/cfg_DONE handshake and a watchdog.
module lupa_cfg_seq #(
    parameter int N_ENTRIES  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clock_40,
    input  logic       reset,
    input  logic       go,
    input  logic       cfg_DONE,
    output logic       start,
    output logic [3:0] nrg,
    output logic       busy,
    output logic       seq_done,
    output logic       err,
    output logic [3:0] idx
);
    import lupa_pkg::*;

    seq_state_t           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           nrg_q, nrg_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [3:0]           rom_data;
    logic                 timeout_hit;
    logic                 gap_met;
    logic                 last_entry;

    // The ROM is addressed with the next index so its one-clock read lands
    // exactly while the FSM sits in LOAD.
    lupa_cfg_rom u_rom (
        .clock_40 (clock_40),
        .addr     (idx_d),
        .data     (rom_data)
    );

    assign timeout_hit = (timer_q >= TIMER_W'(TIMEOUT - 1));
    assign gap_met     = (timer_q >= TIMER_W'(GAP_CYCLES - 1));
    assign last_entry  = (idx_q == 4'(N_ENTRIES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nrg_d   = nrg_q;
        start_d = start_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (go) begin
                    state_d = ST_LOAD;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                nrg_d   = rom_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A done still high from the previous entry must clear first.
                if (!cfg_DONE) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_DONE: begin
                if (cfg_DONE) begin
                    start_d = 1'b0;
                    state_d = ST_GAP;
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_GAP: begin
                if (gap_met && !cfg_DONE) begin
                    if (last_entry) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            start_d = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clock_40) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            nrg_q   <= NRG_NONE;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nrg_q   <= nrg_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    // One saturating timer serves both the gap count and the watchdog;
    // it restarts from zero on every state change.
    always_ff @(posedge clock_40) begin
        if (reset || state_d != state_q) begin
            timer_q <= '0;
        end else if (timer_q != '1) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign start    = start_q;
    assign nrg      = nrg_q;
    assign err      = err_q;
    assign idx      = idx_q;
    assign seq_done = (state_q == ST_FINISH);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_ISSUE) ||
                      (state_q == ST_WAIT_DONE) || (state_q == ST_GAP);

endmodule

// File: doc/lupa_cfg_seq.md
LUPA_CFG_SEQ -- requirements
Module: lupa_cfg_seq

Interface
REQ-001 Parameter N_ENTRIES, default 8, number of table entries issued per sequence (legal 1..16).
REQ-002 Parameter GAP_CYCLES, default 4, minimum idle clocks with start low between entries (legal 1..255).
REQ-003 Parameter TIMEOUT, default 4096, maximum clocks allowed in any wait state before error (legal 2..65535).
REQ-004 clock_40  input  1  sole clock, 40 MHz, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 go  input  1  request to run one configuration sequence; sampled only in IDLE.
REQ-007 cfg_DONE  input  1  completion flag from the downstream SPI uploader (lupa_spi_v2).
REQ-008 start  output  1  level request to the SPI uploader; held high until cfg_DONE is seen.
REQ-009 nrg  output  4  register-select code to the SPI uploader; stable whenever start is high.
REQ-010 busy  output  1  high in every state except IDLE, FINISH and ERROR.
REQ-011 seq_done  output  1  one-clock pulse when all N_ENTRIES entries completed.
REQ-012 err  output  1  sticky timeout flag; cleared only by reset or by the next accepted go.
REQ-013 idx  output  4  index of the entry currently issued.

Function
REQ-014 States: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, FINISH, ERROR.
REQ-015 IDLE: go=1 -> LOAD, idx<=0, err<=0; go=0 -> stay.
REQ-016 LOAD: nrg<=rom[idx] (one-clock ROM read), timer<=0 -> ISSUE.
REQ-017 ISSUE: wait for cfg_DONE=0 (stale done from the previous entry); then start<=1 -> WAIT_DONE.
REQ-018 WAIT_DONE: start held 1; cfg_DONE=1 -> start<=0, timer<=0 -> GAP.
REQ-019 GAP: start 0; exit only when timer>=GAP_CYCLES-1 and cfg_DONE=0; if idx=N_ENTRIES-1 -> FINISH, else idx<=idx+1 -> LOAD.
REQ-020 FINISH: seq_done=1 for exactly one clock -> IDLE.
REQ-021 Latency: go to first start rising edge is 3 clocks when cfg_DONE=0 (IDLE->LOAD->ISSUE->start high).
REQ-022 Timer: 16-bit, cleared on every state entry, saturating; in ISSUE, WAIT_DONE or GAP, reaching TIMEOUT-1 -> ERROR.
REQ-023 ERROR: start<=0, err<=1, busy<=0; remain until go=1 (-> LOAD, idx<=0, err<=0) or reset.
REQ-024 go asserted in any state other than IDLE or ERROR is ignored; no queuing.
REQ-025 cfg_DONE=1 in the same cycle that ISSUE raises start is not counted; a done is accepted only in WAIT_DONE.
REQ-026 nrg changes only in LOAD; start and nrg are registered outputs with no combinational path from any input.
REQ-027 idx never exceeds N_ENTRIES-1; no wrap-around occurs within one sequence.

Reset
REQ-028 reset=1 on a clock edge -> state IDLE, start=0, nrg=0, busy=0, seq_done=0, err=0, idx=0, timer=0, next clock.
REQ-029 reset mid-sequence aborts the sequence; start drops on the reset edge regardless of cfg_DONE; the sequence is not resumed.

Structure
REQ-030 Shared package lupa_pkg holds the state encoding, the 4-bit nrg code constants and the default table contents.
REQ-031 Sub-module lupa_cfg_rom: 16x4 synchronous ROM, input addr[3:0], output data[3:0]; default table 8,1,2,3,4,5,6,7, remaining entries 0.
REQ-032 The timer is shared by GAP counting and timeout detection; no second counter.

Verification
REQ-033 Nominal: reset, go pulse, model returns cfg_DONE 10 clocks after start rises, for 4 clocks -> nrg sequence 8,1,2,3,4,5,6,7; eight start pulses; seq_done one clock; err=0.
REQ-034 Latency/gap: go at cycle 0 with cfg_DONE=0 -> start high at cycle 3; start low between entries for at least 4 clocks.
REQ-035 Stale done: cfg_DONE held high 20 clocks after the entry 0 done -> start for entry 1 does not rise until 1 clock after cfg_DONE falls.
REQ-036 Timeout: TIMEOUT=64, model never asserts cfg_DONE -> ERROR at clock 63 of WAIT_DONE, start=0, err=1, busy=0; a new go restarts at idx 0 and clears err.
REQ-037 Reset mid-op: reset during WAIT_DONE of idx=3 -> next clock all outputs at reset values; a following go restarts at nrg=8.
REQ-038 Ignored go: go pulsed during GAP of idx=2 -> sequence unaffected; exactly 8 entries; exactly one seq_done.
